// File: rtl/seg7_rx.sv
// Purpose: 7-segment receive monitor. Synchronizes the segment bus, accepts stable
//          patterns, decodes them to BCD, checks the 0..9 sequence and counts events.
// Latency: seg_in change sampled at edge k -> registered outputs react at edge k+2+STABLE_CYCLES.
// Backpressure: none; free-running monitor, pulses are single-cycle and never stall.
module seg7_rx #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       seg_in,
    input  logic             clr,
    output logic [3:0]       digit_out,
    output logic             digit_valid,
    output logic             blank,
    output logic             bad_pattern,
    output logic             seq_err,
    output logic             locked,
    output logic [CNT_W-1:0] digit_count,
    output logic [CNT_W-1:0] err_count
);

    localparam int             SCW      = $clog2(STABLE_CYCLES + 1);
    localparam logic [SCW-1:0] STAB_MAX = SCW'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    logic [6:0]       sync1_q, sync1_d;
    logic [6:0]       seg_s_q, seg_s_d;
    logic [SCW-1:0]   stab_q, stab_d;
    logic [6:0]       acc_pat_q, acc_pat_d;
    logic [3:0]       digit_q, digit_d;
    logic [3:0]       ref_q, ref_d;
    state_t           state_q, state_d;
    logic             valid_q, valid_d;
    logic             blank_q, blank_d;
    logic             bad_q, bad_d;
    logic             seq_err_q, seq_err_d;
    logic [CNT_W-1:0] dcnt_q, dcnt_d;
    logic [CNT_W-1:0] ecnt_q, ecnt_d;

    logic             accept;
    logic             pat_is_digit;
    logic             pat_is_blank;
    logic [3:0]       pat_digit;
    logic [3:0]       succ;

    // Two-flop synchronizer and stability counter; counter restarts when seg_s is about to change.
    always_comb begin
        sync1_d = seg_in;
        seg_s_d = sync1_q;
        stab_d  = stab_q;
        if (sync1_q != seg_s_q) begin
            stab_d = '0;
        end else if (stab_q != STAB_MAX) begin
            stab_d = stab_q + SCW'(1);
        end
        // Held long enough and different from the last accepted pattern: fires once per pattern.
        accept = (stab_q == STAB_MAX) && (seg_s_q != acc_pat_q);
    end

    // Segment decode (gfedcba, 1 = lit).
    always_comb begin
        pat_is_digit = 1'b1;
        pat_is_blank = 1'b0;
        pat_digit    = 4'd0;
        unique case (seg_s_q)
            7'h3F: pat_digit = 4'd0;
            7'h06: pat_digit = 4'd1;
            7'h5B: pat_digit = 4'd2;
            7'h4F: pat_digit = 4'd3;
            7'h66: pat_digit = 4'd4;
            7'h6D: pat_digit = 4'd5;
            7'h7D: pat_digit = 4'd6;
            7'h07: pat_digit = 4'd7;
            7'h7F: pat_digit = 4'd8;
            7'h6F: pat_digit = 4'd9;
            7'h00: begin
                pat_is_digit = 1'b0;
                pat_is_blank = 1'b1;
            end
            default: pat_is_digit = 1'b0;
        endcase
    end

    // Sequence FSM and output flags; only an accept event can change anything here.
    always_comb begin
        state_d   = state_q;
        ref_d     = ref_q;
        digit_d   = digit_q;
        blank_d   = blank_q;
        acc_pat_d = acc_pat_q;
        valid_d   = 1'b0;
        bad_d     = 1'b0;
        seq_err_d = 1'b0;
        succ      = (ref_q == 4'd9) ? 4'd0 : ref_q + 4'd1;
        if (accept) begin
            acc_pat_d = seg_s_q;
            if (pat_is_digit) begin
                digit_d = pat_digit;
                valid_d = 1'b1;
                blank_d = 1'b0;
                ref_d   = pat_digit;
                case (state_q)
                    IDLE:    state_d = ARMED;
                    ARMED:   state_d = (pat_digit == succ) ? LOCKED : ARMED;
                    LOCKED: begin
                        if (pat_digit == succ) begin
                            state_d = LOCKED;
                        end else begin
                            state_d   = ARMED;
                            seq_err_d = 1'b1;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end else if (pat_is_blank) begin
                // Blank only shows on the flag; the sequence check carries on across it.
                blank_d = 1'b1;
            end else begin
                bad_d   = 1'b1;
                blank_d = 1'b0;
                state_d = IDLE;
            end
        end
    end

    // Saturating event counters; clr wins over a same-cycle increment.
    always_comb begin
        dcnt_d = dcnt_q;
        ecnt_d = ecnt_q;
        if (clr) begin
            dcnt_d = '0;
            ecnt_d = '0;
        end else begin
            if (valid_d && (dcnt_q != CNT_MAX)) begin
                dcnt_d = dcnt_q + CNT_W'(1);
            end
            if ((seq_err_d || bad_d) && (ecnt_q != CNT_MAX)) begin
                ecnt_d = ecnt_q + CNT_W'(1);
            end
        end
    end

    // State registers; rst clears everything, including any pattern still settling.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= '0;
            seg_s_q   <= '0;
            stab_q    <= '0;
            acc_pat_q <= '0;
            digit_q   <= '0;
            ref_q     <= '0;
            state_q   <= IDLE;
            valid_q   <= 1'b0;
            blank_q   <= 1'b0;
            bad_q     <= 1'b0;
            seq_err_q <= 1'b0;
            dcnt_q    <= '0;
            ecnt_q    <= '0;
        end else begin
            sync1_q   <= sync1_d;
            seg_s_q   <= seg_s_d;
            stab_q    <= stab_d;
            acc_pat_q <= acc_pat_d;
            digit_q   <= digit_d;
            ref_q     <= ref_d;
            state_q   <= state_d;
            valid_q   <= valid_d;
            blank_q   <= blank_d;
            bad_q     <= bad_d;
            seq_err_q <= seq_err_d;
            dcnt_q    <= dcnt_d;
            ecnt_q    <= ecnt_d;
        end
    end

    assign digit_out   = digit_q;
    assign digit_valid = valid_q;
    assign blank       = blank_q;
    assign bad_pattern = bad_q;
    assign seq_err     = seq_err_q;
    assign locked      = (state_q == LOCKED);
    assign digit_count = dcnt_q;
    assign err_count   = ecnt_q;

endmodule

// File: tb/tb_seg7_rx.sv
// Directed bench for seg7_rx: main instance (STABLE_CYCLES=4, CNT_W=8) plus a CNT_W=2 instance.
// Expected digits are queued when a pattern is driven long enough and popped on digit_valid.
module tb_seg7_rx;

    logic       clk = 1'b0;
    logic       rst, rst2, clr;
    logic [6:0] seg_in;

    logic [3:0] digit_out, digit_out2;
    logic       digit_valid, blank, bad_pattern, seq_err, locked;
    logic       digit_valid2, blank2, bad_pattern2, seq_err2, locked2;
    logic [7:0] digit_count, err_count;
    logic [1:0] digit_count2, err_count2;

    int vectors  = 0;
    int miscomp  = 0;
    int nvalid, nbad, nseq, lat;
    logic [6:0] model_acc;
    int exp_q[$];

    always #5 clk = ~clk;

    seg7_rx #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .seg_in(seg_in), .clr(clr),
        .digit_out(digit_out), .digit_valid(digit_valid), .blank(blank),
        .bad_pattern(bad_pattern), .seq_err(seq_err), .locked(locked),
        .digit_count(digit_count), .err_count(err_count)
    );

    seg7_rx #(.STABLE_CYCLES(4), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst2), .seg_in(seg_in), .clr(clr),
        .digit_out(digit_out2), .digit_valid(digit_valid2), .blank(blank2),
        .bad_pattern(bad_pattern2), .seq_err(seq_err2), .locked(locked2),
        .digit_count(digit_count2), .err_count(err_count2)
    );

    function automatic int dig_of(input logic [6:0] p);
        case (p)
            7'h3F: return 0;
            7'h06: return 1;
            7'h5B: return 2;
            7'h4F: return 3;
            7'h66: return 4;
            7'h6D: return 5;
            7'h7D: return 6;
            7'h07: return 7;
            7'h7F: return 8;
            7'h6F: return 9;
            default: return -1;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscomp++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        nvalid = 0;
        nbad   = 0;
        nseq   = 0;
        lat    = -1;
    endtask

    // Drive a pattern for n cycles on the main instance, watching its pulses each cycle.
    task automatic step(input logic [6:0] pat, input int n);
        seg_in = pat;
        if (n >= 8 && pat != model_acc) begin
            model_acc = pat;
            if (dig_of(pat) >= 0) exp_q.push_back(dig_of(pat));
        end
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (digit_valid) begin
                nvalid++;
                lat = i;
                if (exp_q.size() == 0) chk("queue_underflow", exp_q.size(), 1);
                else chk("digit_pop", digit_out, exp_q.pop_front());
            end
            if (bad_pattern) nbad++;
            if (seq_err) nseq++;
        end
    endtask

    task automatic do_reset(input int n);
        rst    = 1'b1;
        seg_in = 7'h00;
        repeat (n) @(negedge clk);
        rst       = 1'b0;
        model_acc = 7'h00;
        exp_q.delete();
    endtask

    initial begin
        // Reset dominates seg_in and clr.
        rst = 1'b1; rst2 = 1'b1; clr = 1'b1; seg_in = 7'h3F;
        model_acc = 7'h00;
        clear_mon();
        repeat (3) @(negedge clk);
        chk("rst_digit_out", digit_out, 0);
        chk("rst_valid", digit_valid, 0);
        chk("rst_blank", blank, 0);
        chk("rst_bad", bad_pattern, 0);
        chk("rst_seq", seq_err, 0);
        chk("rst_locked", locked, 0);
        chk("rst_dcnt", digit_count, 0);
        chk("rst_ecnt", err_count, 0);
        rst = 1'b0; clr = 1'b0;

        // First digit: one pulse at edge 1+2+4 counted from the drive.
        step(7'h3F, 10);
        chk("t1_nvalid", nvalid, 1);
        chk("t1_latency", lat, 7);
        chk("t1_digit", digit_out, 0);
        chk("t1_locked", locked, 0);
        chk("t1_dcnt", digit_count, 1);

        // Full 0..9,0 sweep.
        do_reset(3);
        clear_mon();
        step(7'h3F, 20);
        chk("t2_locked_d0", locked, 0);
        step(7'h06, 20); chk("t2_locked_d1", locked, 1);
        step(7'h5B, 20); step(7'h4F, 20); step(7'h66, 20); step(7'h6D, 20);
        step(7'h7D, 20); step(7'h07, 20); step(7'h7F, 20); step(7'h6F, 20);
        chk("t2_locked_d9", locked, 1);
        step(7'h3F, 20);
        chk("t2_nvalid", nvalid, 11);
        chk("t2_locked_wrap", locked, 1);
        chk("t2_dcnt", digit_count, 11);
        chk("t2_ecnt", err_count, 0);
        chk("t2_drain", exp_q.size(), 0);

        // Short glitch to 8 and back to an already-accepted 1.
        step(7'h06, 20);
        clear_mon();
        step(7'h7F, 3);
        step(7'h06, 20);
        chk("t3_nvalid", nvalid, 0);
        chk("t3_nbad", nbad, 0);
        chk("t3_digit", digit_out, 1);
        chk("t3_locked", locked, 1);

        // Out-of-sequence digit while locked.
        step(7'h5B, 20); step(7'h4F, 20);
        chk("t4_locked3", locked, 1);
        clear_mon();
        step(7'h6D, 20);
        chk("t4_nseq", nseq, 1);
        chk("t4_locked", locked, 0);
        chk("t4_ecnt", err_count, 1);
        chk("t4_digit", digit_out, 5);
        step(7'h7D, 20);
        chk("t4_relock", locked, 1);
        chk("t4_nseq_after", nseq, 1);

        // Bad pattern, then blank.
        clear_mon();
        step(7'h49, 20);
        chk("t5_nbad", nbad, 1);
        chk("t5_ecnt", err_count, 2);
        chk("t5_locked", locked, 0);
        chk("t5_digit", digit_out, 6);
        step(7'h00, 20);
        chk("t5_blank", blank, 1);
        chk("t5_nvalid", nvalid, 0);
        chk("t5_digit_held", digit_out, 6);

        // 7, blank, 7 while locked re-accepts 7 and flags a sequence error.
        step(7'h7D, 20); step(7'h07, 20);
        chk("t5b_locked", locked, 1);
        step(7'h00, 20);
        chk("t5b_blank", blank, 1);
        clear_mon();
        step(7'h07, 20);
        chk("t5b_nvalid", nvalid, 1);
        chk("t5b_nseq", nseq, 1);
        chk("t5b_ecnt", err_count, 3);
        chk("t5b_blank_off", blank, 0);
        chk("t5b_locked", locked, 0);

        // clr zeroes counters only; the FSM still holds ref=7.
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_dcnt", digit_count, 0);
        chk("clr_ecnt", err_count, 0);
        chk("clr_digit", digit_out, 7);
        step(7'h7F, 20);
        chk("clr_relock", locked, 1);
        chk("clr_dcnt_after", digit_count, 1);
        chk("clr_drain", exp_q.size(), 0);

        // Reset three cycles into a stability window.
        seg_in = 7'h5B;
        repeat (3) @(negedge clk);
        rst = 1'b1; seg_in = 7'h00;
        repeat (2) @(negedge clk);
        chk("rstmid_digit", digit_out, 0);
        chk("rstmid_locked", locked, 0);
        chk("rstmid_dcnt", digit_count, 0);
        rst = 1'b0;
        model_acc = 7'h00;
        exp_q.delete();
        clear_mon();
        step(7'h00, 12);
        chk("rstmid_nvalid", nvalid, 0);
        chk("rstmid_nbad", nbad, 0);
        chk("rstmid_blank", blank, 0);
        chk("rstmid_ecnt", err_count, 0);

        // Narrow counters saturate at 3; clr coincident with an accept gives 0.
        rst = 1'b1; rst2 = 1'b0;
        seg_in = 7'h3F; repeat (20) @(negedge clk);
        seg_in = 7'h06; repeat (20) @(negedge clk);
        seg_in = 7'h5B; repeat (20) @(negedge clk);
        seg_in = 7'h4F; repeat (20) @(negedge clk);
        seg_in = 7'h66; repeat (20) @(negedge clk);
        chk("t6_dcnt_sat", digit_count2, 3);
        chk("t6_digit", digit_out2, 4);
        chk("t6_locked", locked2, 1);
        seg_in = 7'h6D;
        repeat (6) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        chk("t6_clr_valid", digit_valid2, 1);
        chk("t6_clr_dcnt", digit_count2, 0);
        clr = 1'b0;
        @(negedge clk);
        chk("t6_clr_hold", digit_count2, 0);
        chk("t6_digit5", digit_out2, 5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscomp);
        $finish;
    end

endmodule
